seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumes the CPU's 32-bit `disp7seg` value and its `statJ`/`statR`/`statI`/`statTC` counters.
- Drives a time-multiplexed 8-digit common-anode seven-segment display, one digit at a time, showing the selected word as 8 hex digits.
- Sits between the CPU top level and the board pins.
- Snapshots the selected word once per scan frame so the displayed digits never tear.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit; must be at least 2.
- ACTIVE_LOW, 1: when 1, `an`, `seg` and `dp` are driven active-low; when 0, active-high.
- BLANK_LEADING, 1: when 1, leading-zero digits are blanked.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hex_in  in  32  `disp7seg` word from the syscall decoder
- stat_j  in  32  J-type instruction count
- stat_r  in  32  R-type instruction count
- stat_i  in  32  I-type instruction count
- stat_tc  in  32  total cycle count
- src_sel  in  3  source select: 0=hex_in, 1=stat_j, 2=stat_r, 3=stat_i, 4=stat_tc, 5-7 treated as 0
- an  out  8  digit enables; bit k = digit k, digit 0 least significant nibble
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (synchronous, active-high), all of these take effect at the clock edge:
  - div_cnt=0, dig_idx=0, shadow=0, frame_tick=0.
  - `an`, `seg` and `dp` all go inactive: all ones if ACTIVE_LOW, else zeros.
  - Reset asserted mid-frame aborts the scan; there is no partial-frame state.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, dig_idx increments modulo 8 (7 wraps to 0).
- Snapshot:
  - In any cycle with div_cnt==0 && dig_idx==0, shadow loads the selected source.
  - This includes the first cycle after reset deasserts.
  - Changes to the inputs or to `src_sel` at any other time are invisible until the next frame start.
- Frame period is exactly 8*REFRESH_DIV cycles.
- frame_tick:
  - Registered. High for exactly one cycle: the cycle after a cycle in which div_cnt==REFRESH_DIV-1 and dig_idx==7.
  - That high cycle is the one in which div_cnt==0 and dig_idx==0.
  - Not asserted for the initial frame after reset.
- Outputs:
  - Registered, one cycle of latency from (dig_idx, shadow).
  - The cycle after reset deasserts shows digit 0 of the old shadow (0), which is acceptable.
  - `an`: exactly one bit active, bit dig_idx, unless that digit is blanked, in which case all bits are inactive.
- Segment encoding (active-high logical value, inverted when ACTIVE_LOW):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blanking, when BLANK_LEADING=1:
  - Digit k (k≥1) is blanked iff shadow nibbles k..7 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blanked digit drives `an` inactive and `seg` inactive.
- dp is active only while digit 7 is scanned and the latched source select is nonzero (statistics mode indicator).
- src_sel is latched with shadow.
- dp timing:
  - dp on digit 7 is independent of blanking; `an` stays inactive if digit 7 is blanked.
  - dp is therefore visible only when digit 7 is enabled.
- Simultaneous events: reset wins over a snapshot load and over frame_tick.

Decomposition:
- Shared package `seg7_pkg` holds:
  - source-select constants SRC_HEX=0, SRC_J=1, SRC_R=2, SRC_I=3, SRC_TC=4;
  - the 16-entry hex-to-segment constant table;
  - NUM_DIGITS=8.
- One combinational sub-module, `hex_to_seg7` (4-bit nibble in, 7-bit active-high segments out), instantiated once.
- The divider, scan counter, snapshot and blanking logic stay in the top module.

Test Plan (REFRESH_DIV=4, ACTIVE_LOW=1, BLANK_LEADING=1):
- Reset release: assert reset 3 cycles with hex_in=0 -> `an`=FF, `seg`=7F, `dp`=1, frame_tick=0; first frame_tick exactly 32 cycles after the first post-reset cycle, then every 32.
- Value display: hex_in=0x000000A5, src_sel=0 -> digit0 `an`=FE, `seg`=12 (5); digit1 `an`=FD, `seg`=08 (A); digits 2-7 `an`=FF, `seg`=7F.
- Zero and full values:
  - hex_in=0 -> only digit0 lit, `seg`=40.
  - hex_in=0xFFFFFFFF -> all 8 digits lit in turn, `an` walking FE,FD,...,7F, `seg`=0E each.
- Source select: stat_tc=0x12345678, src_sel=4 -> digit7 shows 1 (`seg`=79) with `dp`=0; digit0 shows 8 (`seg`=00).
- Tear-free snapshot: change hex_in 0x11111111 -> 0x22222222 while dig_idx=3 -> remainder of frame still shows 1 on every digit; 2 appears only after the next frame_tick.
- Reset mid-frame: assert reset while dig_idx=5 -> next cycle outputs inactive, div_cnt and dig_idx back to 0, and the new frame snapshots the current source.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the seven-segment scan driver:
//   - source-select codes for the word being displayed
//   - active-high hex-to-segment font, bit order {g,f,e,d,c,b,a}
//   - number of scanned digits
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [2:0] SRC_HEX = 3'd0;
  localparam logic [2:0] SRC_J   = 3'd1;
  localparam logic [2:0] SRC_R   = 3'd2;
  localparam logic [2:0] SRC_I   = 3'd3;
  localparam logic [2:0] SRC_TC  = 3'd4;

  // Entry [h] is the active-high segment pattern for nibble h.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
// Combinational nibble-to-segment decoder, active-high output.
// Ports:
//   i_nibble  in  4  hex digit value
//   o_seg     out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes a 32-bit word onto an 8-digit common-anode seven-segment
// display as 8 hex digits. The selected word is snapshotted at every frame
// start so a frame never mixes digits from two different values.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   hex_in              disp7seg word
//   stat_j/r/i/tc       instruction-class and cycle counters
//   src_sel             0=hex_in 1=J 2=R 3=I 4=TC, 5-7 behave as 0
//   an[7:0]             digit enables, bit k drives digit k
//   seg[6:0]            segments {g,f,e,d,c,b,a}
//   dp                  decimal point, marks statistics mode on digit 7
//   frame_tick          one-cycle pulse at each frame start
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] hex_in,
  input  logic [31:0] stat_j,
  input  logic [31:0] stat_r,
  input  logic [31:0] stat_i,
  input  logic [31:0] stat_tc,
  input  logic [2:0]  src_sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int               DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGITS - 1);
  // XOR mask that turns an active-high value into the pin polarity.
  localparam logic             POL      = ACTIVE_LOW;

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_dig_idx;
  logic [31:0]      r_shadow;
  logic [2:0]       r_src;

  logic        w_div_wrap;
  logic        w_frame_start;
  logic        w_frame_end;
  logic [2:0]  w_src_eff;
  logic [31:0] w_src_word;
  logic [31:0] w_shifted;
  logic [3:0]  w_nibble;
  logic        w_blank;
  logic [6:0]  w_seg_lit;
  logic [7:0]  w_an_on;
  logic [6:0]  w_seg_on;
  logic        w_dp_on;

  assign w_div_wrap    = (r_div_cnt == DIV_LAST);
  assign w_frame_start = (r_div_cnt == '0) && (r_dig_idx == 3'd0);
  assign w_frame_end   = w_div_wrap && (r_dig_idx == DIG_LAST);

  // Unused select codes fold onto hex_in, so dp also stays off for them.
  always_comb begin
    w_src_eff  = SRC_HEX;
    w_src_word = hex_in;
    case (src_sel)
      SRC_J:   begin w_src_eff = SRC_J;  w_src_word = stat_j;  end
      SRC_R:   begin w_src_eff = SRC_R;  w_src_word = stat_r;  end
      SRC_I:   begin w_src_eff = SRC_I;  w_src_word = stat_i;  end
      SRC_TC:  begin w_src_eff = SRC_TC; w_src_word = stat_tc; end
      default: begin w_src_eff = SRC_HEX; w_src_word = hex_in; end
    endcase
  end

  // Shifting the current digit down to bit 0 gives both its nibble and,
  // via the all-zero test, whether it and every more significant digit
  // are zero (the leading-zero blank condition).
  assign w_shifted = r_shadow >> {r_dig_idx, 2'b00};
  assign w_nibble  = w_shifted[3:0];
  assign w_blank   = BLANK_LEADING && (r_dig_idx != 3'd0) && (w_shifted == 32'd0);

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_lit)
  );

  assign w_an_on  = w_blank ? 8'h00 : (8'b1 << r_dig_idx);
  assign w_seg_on = w_blank ? 7'h00 : w_seg_lit;
  // dp ignores blanking; with digit 7 blanked its anode is off anyway.
  assign w_dp_on  = (r_dig_idx == DIG_LAST) && (r_src != SRC_HEX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_dig_idx  <= 3'd0;
      r_shadow   <= 32'd0;
      r_src      <= SRC_HEX;
      frame_tick <= 1'b0;
      an         <= {8{POL}};
      seg        <= {7{POL}};
      dp         <= POL;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_dig_idx <= r_dig_idx + 3'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (w_frame_start) begin
        r_shadow <= w_src_word;
        r_src    <= w_src_eff;
      end

      frame_tick <= w_frame_end;
      an         <= w_an_on  ^ {8{POL}};
      seg        <= w_seg_on ^ {7{POL}};
      dp         <= w_dp_on  ^ POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int RD    = 4;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hex_in = '0, stat_j = '0, stat_r = '0, stat_i = '0, stat_tc = '0;
  logic [2:0]  src_sel = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_driver #(.REFRESH_DIV(RD), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .stat_j(stat_j), .stat_r(stat_r),
    .stat_i(stat_i), .stat_tc(stat_tc), .src_sel(src_sel), .an(an), .seg(seg),
    .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // values to be applied for the next cycle
  logic        d_reset = 1'b1;
  logic [31:0] d_hex = '0, d_j = '0, d_r = '0, d_i = '0, d_tc = '0;
  logic [2:0]  d_sel = '0;

  // reference model: m_n = cycles since reset release, m_val/m_src = word on display
  int          m_n = 0;
  logic [31:0] m_val = '0;
  logic [2:0]  m_src = '0;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_ft = 1'b0;

  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_ft;

  typedef struct {
    logic [31:0] hex;
    logic [2:0]  sel;
    int          dig;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (model cycle %0d, t=%0t)", name, act, exp, m_n, $time);
    end
  endtask

  task automatic model_digit(input int d, input logic [31:0] v, input logic [2:0] s);
    logic [31:0] upper;
    logic        blank;
    upper = v >> (4 * d);
    blank = (d != 0) && (upper == 0);
    e_an  = blank ? 8'hFF : ~(8'(1) << d);
    e_seg = blank ? 7'h7F : ~font(upper[3:0]);
    e_dp  = (d == 7 && s != 0) ? 1'b0 : 1'b1;
  endtask

  // One clock: observe and check this cycle, then drive inputs and
  // advance the model to predict the next cycle.
  task automatic step();
    int d;
    @(posedge clk);
    #1;
    o_an = an; o_seg = seg; o_dp = dp; o_ft = frame_tick;
    check("an", o_an, e_an);
    check("seg", o_seg, e_seg);
    check("dp", o_dp, e_dp);
    check("frame_tick", o_ft, e_ft);
    reset = d_reset; hex_in = d_hex; stat_j = d_j; stat_r = d_r;
    stat_i = d_i; stat_tc = d_tc; src_sel = d_sel;
    if (d_reset) begin
      m_n = 0; m_val = '0; m_src = '0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      d = (m_n / RD) % 8;
      model_digit(d, m_val, m_src);
      e_ft = ((m_n + 1) % FRAME) == 0;
      if (m_n % FRAME == 0) begin
        m_src = (d_sel > 3'd4) ? 3'd0 : d_sel;
        case (m_src)
          3'd1:    m_val = d_j;
          3'd2:    m_val = d_r;
          3'd3:    m_val = d_i;
          3'd4:    m_val = d_tc;
          default: m_val = d_hex;
        endcase
      end
      m_n++;
    end
  endtask

  // Steps until a frame_tick is observed; returns with that cycle observed.
  task automatic wait_tick(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < FRAME + 8 && !got; k++) begin
      step();
      if (o_ft) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no frame_tick within %0d cycles", name, FRAME + 8);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit got;

    d_j = 32'h0000_0001; d_r = 32'h0F00_0000; d_i = 32'h8000_0000; d_tc = 32'h1234_5678;

    // reset release and frame cadence
    d_reset = 1'b1; d_hex = '0; d_sel = 3'd0;
    repeat (3) step();
    check("rst_an", o_an, 8'hFF);
    check("rst_seg", o_seg, 7'h7F);
    check("rst_dp", o_dp, 1'b1);
    check("rst_ft", o_ft, 1'b0);
    d_reset = 1'b0;
    step();                      // observes first post-reset cycle
    for (int rep = 0; rep < 2; rep++) begin
      cnt = 0; got = 0;
      while (!got && cnt < FRAME + 8) begin
        step(); cnt++;
        if (o_ft) got = 1;
      end
      check("tick_period", cnt, FRAME);
    end

    // table-driven digit vectors
    vecs.push_back('{32'h0000_00A5, 3'd0, 0, 8'hFE, 7'h12, 1'b1});
    vecs.push_back('{32'h0000_00A5, 3'd0, 1, 8'hFD, 7'h08, 1'b1});
    vecs.push_back('{32'h0000_00A5, 3'd0, 2, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h0000_00A5, 3'd0, 7, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h0000_0000, 3'd0, 0, 8'hFE, 7'h40, 1'b1});
    vecs.push_back('{32'h0000_0000, 3'd0, 3, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 3'd0, 0, 8'hFE, 7'h0E, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 3'd0, 4, 8'hEF, 7'h0E, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 3'd0, 7, 8'h7F, 7'h0E, 1'b1});
    vecs.push_back('{32'h0000_0000, 3'd4, 7, 8'h7F, 7'h79, 1'b0});
    vecs.push_back('{32'h0000_0000, 3'd4, 0, 8'hFE, 7'h00, 1'b1});
    vecs.push_back('{32'h0000_00A5, 3'd6, 1, 8'hFD, 7'h08, 1'b1});
    vecs.push_back('{32'h0000_00A5, 3'd6, 7, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h0000_0000, 3'd1, 7, 8'hFF, 7'h7F, 1'b0});
    vecs.push_back('{32'h0000_0000, 3'd2, 6, 8'hBF, 7'h0E, 1'b1});
    vecs.push_back('{32'h0000_0000, 3'd2, 7, 8'hFF, 7'h7F, 1'b0});
    vecs.push_back('{32'h0000_0000, 3'd3, 3, 8'hF7, 7'h40, 1'b1});
    foreach (vecs[v]) begin
      d_hex = vecs[v].hex; d_sel = vecs[v].sel;
      wait_tick("vec_tick");
      repeat (2 + 4 * vecs[v].dig) step();
      check($sformatf("vec%0d_an", v), o_an, vecs[v].an);
      check($sformatf("vec%0d_seg", v), o_seg, vecs[v].seg);
      check($sformatf("vec%0d_dp", v), o_dp, vecs[v].dp);
    end

    // tear-free: change the word while digit 3 is being scanned
    d_hex = 32'h1111_1111; d_sel = 3'd0;
    wait_tick("tear_tick");
    repeat (13) step();
    d_hex = 32'h2222_2222;
    for (int c = 14; c <= 34; c++) begin
      step();
      if (c >= 18 && c <= 30 && (c - 2) % 4 == 0) check("tear_old", o_seg, 7'h79);
      if (c == 32) check("tear_tick", o_ft, 1'b1);
      if (c == 34) check("tear_new", o_seg, 7'h24);
    end

    // reset while digit 5 is scanned
    d_hex = 32'h0000_ABCD;
    wait_tick("mid_tick");
    repeat (21) step();
    d_reset = 1'b1;
    step();
    d_reset = 1'b0; d_hex = 32'h0000_0003;
    step();
    check("midrst_an", o_an, 8'hFF);
    check("midrst_seg", o_seg, 7'h7F);
    check("midrst_dp", o_dp, 1'b1);
    check("midrst_ft", o_ft, 1'b0);
    step();
    step();
    check("midrst_new_an", o_an, 8'hFE);
    check("midrst_new_seg", o_seg, 7'h30);

    // randomized traffic against the model
    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 7) == 0) d_hex = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d_j  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d_r  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d_i  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d_tc = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0)  d_sel = 3'($urandom_range(0, 7));
      d_reset = ($urandom_range(0, 299) == 0);
      step();
    end
    d_reset = 1'b0;
    repeat (FRAME) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
